// File: rtl/ws2811_frame_scheduler.sv
// Frame sequencer and double-buffered, round-robin shared colour store for a WS2811 array controller.
// Optional statistics counters are compiled in with WS2811_FRAME_STATS_EN.
module ws2811_frame_scheduler #(
  parameter int FRAME_CYCLES = 1000000,
  parameter int TX_CYCLES    = 12000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  led_count_cfg,
  input  logic        a_wr,
  input  logic [2:0]  a_idx,
  input  logic [23:0] a_rgb,
  input  logic        a_commit,
  output logic        a_ack,
  input  logic        b_wr,
  input  logic [2:0]  b_idx,
  input  logic [23:0] b_rgb,
  input  logic        b_commit,
  output logic        b_ack,
  output logic        enable,
  output logic        use_external_rgb,
  output logic [7:0]  led_count,
  output logic [23:0] external_led0,
  output logic [23:0] external_led1,
  output logic [23:0] external_led2,
  output logic [23:0] external_led3,
  output logic [23:0] external_led4,
`ifdef WS2811_FRAME_STATS_EN
  output logic [15:0] frames_sent,
  output logic [15:0] commits_merged,
`endif
  output logic        frame_start,
  output logic        frame_updated
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LATCH = 2'd1, S_SEND = 2'd2, S_GAP = 2'd3} state_t;

  localparam logic [23:0] TX_LAST    = 24'(TX_CYCLES);
  localparam logic [23:0] FRAME_LAST = 24'(FRAME_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        enable_q, enable_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_updated_q, frame_updated_d;
  logic        use_ext_q, use_ext_d;
  logic [7:0]  led_count_q, led_count_d;
  logic        commit_flag_q, commit_flag_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic        rr_last_b_q, rr_last_b_d;
  logic [23:0] pend_q [0:4];
  logic [23:0] pend_d [0:4];
  logic [23:0] act_q [0:4];
  logic [23:0] act_d [0:4];

  logic        latch_s, copy_s, a_req_s, b_req_s, a_grant_s, b_grant_s, wr_en_s;
  logic [2:0]  wr_idx_s;
  logic [23:0] wr_rgb_s;

  // State register and frame position counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt_q is the cycle index within the frame, 0 in S_LATCH
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 24'd0;
        if (run) state_d = S_LATCH;
        else     state_d = S_IDLE;
      end
      S_LATCH: begin
        cnt_d   = 24'd1;
        state_d = S_SEND;
      end
      S_SEND: begin
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == TX_LAST) state_d = S_GAP;
        else                  state_d = S_SEND;
      end
      S_GAP: begin
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = 24'd0;
          state_d = run ? S_LATCH : S_IDLE;
        end else begin
          cnt_d   = cnt_q + 24'd1;
          state_d = S_GAP;
        end
      end
      default: begin
        cnt_d   = 24'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output, arbitration and buffer next-state logic
  always_comb begin
    latch_s         = (state_q == S_LATCH);
    copy_s          = latch_s & commit_flag_q;
    enable_d        = (state_d == S_SEND);
    frame_start_d   = latch_s;
    frame_updated_d = copy_s;
    use_ext_d       = use_ext_q | copy_s;
    led_count_d     = latch_s ? led_count_cfg : led_count_q;

    // A commit in the latch cycle wins over the clear, deferring it to the next frame
    if (a_commit || b_commit) commit_flag_d = 1'b1;
    else if (copy_s)          commit_flag_d = 1'b0;
    else                      commit_flag_d = commit_flag_q;

    a_req_s   = a_wr & ~a_ack_q;
    b_req_s   = b_wr & ~b_ack_q;
    a_grant_s = a_req_s & (~b_req_s | rr_last_b_q);
    b_grant_s = b_req_s & ~a_grant_s;
    a_ack_d   = a_grant_s;
    b_ack_d   = b_grant_s;
    wr_en_s   = a_grant_s | b_grant_s;
    wr_idx_s  = a_grant_s ? a_idx : b_idx;
    wr_rgb_s  = a_grant_s ? a_rgb : b_rgb;

    if (a_grant_s)      rr_last_b_d = 1'b0;
    else if (b_grant_s) rr_last_b_d = 1'b1;
    else                rr_last_b_d = rr_last_b_q;

    for (int i = 0; i < 5; i++) begin
      if (wr_en_s && (wr_idx_s == 3'(i))) pend_d[i] = wr_rgb_s;
      else                                 pend_d[i] = pend_q[i];
      if (copy_s) act_d[i] = pend_q[i];
      else        act_d[i] = act_q[i];
    end
  end

  // Registered outputs and colour buffers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable_q        <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_updated_q <= 1'b0;
      use_ext_q       <= 1'b0;
      led_count_q     <= 8'd0;
      commit_flag_q   <= 1'b0;
      a_ack_q         <= 1'b0;
      b_ack_q         <= 1'b0;
      rr_last_b_q     <= 1'b1;
      for (int i = 0; i < 5; i++) begin
        pend_q[i] <= 24'd0;
        act_q[i]  <= 24'd0;
      end
    end else begin
      enable_q        <= enable_d;
      frame_start_q   <= frame_start_d;
      frame_updated_q <= frame_updated_d;
      use_ext_q       <= use_ext_d;
      led_count_q     <= led_count_d;
      commit_flag_q   <= commit_flag_d;
      a_ack_q         <= a_ack_d;
      b_ack_q         <= b_ack_d;
      rr_last_b_q     <= rr_last_b_d;
      for (int i = 0; i < 5; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

`ifdef WS2811_FRAME_STATS_EN
  logic [15:0] frames_q, frames_d, merged_q, merged_d;

  // Statistics next-state: frame count wraps, merge count saturates
  always_comb begin
    frames_d = latch_s ? (frames_q + 16'd1) : frames_q;
    if ((a_commit || b_commit) && commit_flag_q && (merged_q != 16'hFFFF)) merged_d = merged_q + 16'd1;
    else                                                                   merged_d = merged_q;
  end

  // Statistics registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frames_q <= 16'd0;
      merged_q <= 16'd0;
    end else begin
      frames_q <= frames_d;
      merged_q <= merged_d;
    end
  end

  assign frames_sent    = frames_q;
  assign commits_merged = merged_q;
`endif

  assign enable           = enable_q;
  assign use_external_rgb = use_ext_q;
  assign led_count        = led_count_q;
  assign frame_start      = frame_start_q;
  assign frame_updated    = frame_updated_q;
  assign a_ack            = a_ack_q;
  assign b_ack            = b_ack_q;
  assign external_led0    = act_q[0];
  assign external_led1    = act_q[1];
  assign external_led2    = act_q[2];
  assign external_led3    = act_q[3];
  assign external_led4    = act_q[4];

endmodule

// File: tb/tb_ws2811_frame_scheduler.sv
// Directed bench for ws2811_frame_scheduler: a frame-position model predicts every output each cycle,
// backed by hand-computed literal checks.
module tb_ws2811_frame_scheduler;
  localparam int FRAME = 100;
  localparam int TX    = 20;

  logic clock = 1'b0, reset = 1'b0, run = 1'b0;
  logic [7:0] led_count_cfg = 8'd7;
  logic a_wr = 1'b0, a_commit = 1'b0, b_wr = 1'b0, b_commit = 1'b0;
  logic [2:0] a_idx = 3'd0, b_idx = 3'd0;
  logic [23:0] a_rgb = 24'd0, b_rgb = 24'd0;
  logic a_ack, b_ack, enable, use_external_rgb, frame_start, frame_updated;
  logic [7:0] led_count;
  logic [23:0] led_w [5];
`ifdef WS2811_FRAME_STATS_EN
  logic [15:0] frames_sent, commits_merged;
`endif

  int n_checks = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  ws2811_frame_scheduler #(.FRAME_CYCLES(FRAME), .TX_CYCLES(TX)) dut (
    .clock(clock), .reset(reset), .run(run), .led_count_cfg(led_count_cfg),
    .a_wr(a_wr), .a_idx(a_idx), .a_rgb(a_rgb), .a_commit(a_commit), .a_ack(a_ack),
    .b_wr(b_wr), .b_idx(b_idx), .b_rgb(b_rgb), .b_commit(b_commit), .b_ack(b_ack),
    .enable(enable), .use_external_rgb(use_external_rgb), .led_count(led_count),
    .external_led0(led_w[0]), .external_led1(led_w[1]), .external_led2(led_w[2]),
    .external_led3(led_w[3]), .external_led4(led_w[4]),
`ifdef WS2811_FRAME_STATS_EN
    .frames_sent(frames_sent), .commits_merged(commits_merged),
`endif
    .frame_start(frame_start), .frame_updated(frame_updated)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: m_pos is the position of the current cycle inside the frame (-1 = idle, 0 = latch cycle)
  int m_pos;
  bit m_flag, m_use, m_upd, m_aack, m_back, m_last_b, ra, rb, ga, gb;
  logic [7:0] m_lc;
  logic [23:0] m_pend [5];
  logic [23:0] m_act [5];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pos = -1; m_flag = 0; m_use = 0; m_upd = 0; m_aack = 0; m_back = 0; m_last_b = 1; m_lc = 8'd0;
      for (int i = 0; i < 5; i++) begin m_pend[i] = 24'd0; m_act[i] = 24'd0; end
    end else begin
      m_upd = 0;
      if (m_pos == 0) begin
        m_lc = led_count_cfg;
        if (m_flag) begin m_act = m_pend; m_flag = 0; m_upd = 1; m_use = 1; end
      end
      if (a_commit || b_commit) m_flag = 1;
      ra = a_wr && !m_aack;
      rb = b_wr && !m_back;
      ga = ra && (!rb || m_last_b);
      gb = rb && !ga;
      if (ga) begin if (a_idx < 3'd5) m_pend[a_idx] = a_rgb; m_last_b = 0; end
      if (gb) begin if (b_idx < 3'd5) m_pend[b_idx] = b_rgb; m_last_b = 1; end
      m_aack = ga; m_back = gb;
      if (m_pos == -1 || m_pos == FRAME - 1) m_pos = run ? 0 : -1;
      else m_pos = m_pos + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (cmp_en && reset) begin
      chk("enable", {31'd0, enable}, {31'd0, (m_pos >= 1 && m_pos <= TX)});
      chk("frame_start", {31'd0, frame_start}, {31'd0, (m_pos == 1)});
      chk("frame_updated", {31'd0, frame_updated}, {31'd0, m_upd});
      chk("use_external_rgb", {31'd0, use_external_rgb}, {31'd0, m_use});
      chk("led_count", {24'd0, led_count}, {24'd0, m_lc});
      chk("a_ack", {31'd0, a_ack}, {31'd0, m_aack});
      chk("b_ack", {31'd0, b_ack}, {31'd0, m_back});
      for (int i = 0; i < 5; i++) chk("external_led", {8'd0, led_w[i]}, {8'd0, m_act[i]});
    end
  end

  task automatic wait_pos(input int p);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clock);
      if (m_pos == p) break;
    end
    if (k == 400) chk("wait_pos_timeout", 32'd1, 32'd0);
  endtask

  task automatic write_a(input logic [2:0] idx, input logic [23:0] rgb);
    int k;
    a_wr = 1'b1; a_idx = idx; a_rgb = rgb;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (a_ack) break;
    end
    if (k == 20) chk("a_ack_timeout", 32'd1, 32'd0);
    a_wr = 1'b0;
  endtask

  task automatic commit_a();
    a_commit = 1'b1;
    @(negedge clock);
    a_commit = 1'b0;
  endtask

  int fs_cnt, en_cnt;
  logic [1:0] exp_seq [4];

  initial begin
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
    repeat (3) @(negedge clock);
    reset = 1'b1; cmp_en = 1'b1; run = 1'b1;

    // Periodic refresh without commits
    wait_pos(1);
    chk("first_frame_start", {31'd0, frame_start}, 32'd1);
    chk("first_led_count", {24'd0, led_count}, 32'd7);
    fs_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      fs_cnt += int'(frame_start);
      en_cnt += int'(enable);
    end
    chk("frame_start_count_200", fs_cnt, 32'd2);
    chk("enable_count_200", en_cnt, 32'd40);
    chk("no_commit_use_ext", {31'd0, use_external_rgb}, 32'd0);
    chk("no_commit_led0", {8'd0, led_w[0]}, 32'd0);

    // Asynchronous reset in the middle of transmission
    repeat (5) @(negedge clock);
    chk("enable_before_reset", {31'd0, enable}, 32'd1);
    #2 reset = 1'b0; run = 1'b0;
    #1;
    chk("reset_enable", {31'd0, enable}, 32'd0);
    chk("reset_led_count", {24'd0, led_count}, 32'd0);
    chk("reset_frame_start", {31'd0, frame_start}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_enable", {31'd0, enable}, 32'd0);

    // Both requesters hold wr to the same index: A first, alternating, B last
    a_wr = 1'b1; a_idx = 3'd2; a_rgb = 24'h111111;
    b_wr = 1'b1; b_idx = 3'd2; b_rgb = 24'h222222;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("grant_seq", {30'd0, a_ack, b_ack}, {30'd0, exp_seq[i]});
    end
    a_wr = 1'b0; b_wr = 1'b0;

    // A writes two colours, an out-of-range index, then commits while idle
    write_a(3'd0, 24'hFF0000);
    write_a(3'd4, 24'h0000FF);
    write_a(3'd7, 24'hABCDEF);
    commit_a();
    run = 1'b1;
    wait_pos(1);
    chk("commit_led0", {8'd0, led_w[0]}, 32'h00FF0000);
    chk("commit_led4", {8'd0, led_w[4]}, 32'h000000FF);
    chk("later_grant_led2", {8'd0, led_w[2]}, 32'h00222222);
    chk("commit_frame_updated", {31'd0, frame_updated}, 32'd1);
    chk("commit_use_ext", {31'd0, use_external_rgb}, 32'd1);

    // Commit and write inside the latch cycle are deferred by one frame
    write_a(3'd3, 24'h0A0B0C);
    commit_a();
    wait_pos(0);
    a_commit = 1'b1; a_wr = 1'b1; a_idx = 3'd1; a_rgb = 24'h00FF00;
    @(negedge clock);
    chk("latch_write_ack", {31'd0, a_ack}, 32'd1);
    a_commit = 1'b0; a_wr = 1'b0;
    chk("latch_frame_updated", {31'd0, frame_updated}, 32'd1);
    chk("latch_led3", {8'd0, led_w[3]}, 32'h000A0B0C);
    chk("latch_led1_omitted", {8'd0, led_w[1]}, 32'd0);
    wait_pos(1);
    chk("deferred_led1", {8'd0, led_w[1]}, 32'h0000FF00);
    chk("deferred_frame_updated", {31'd0, frame_updated}, 32'd1);

    // led_count only follows led_count_cfg at frame boundaries
    led_count_cfg = 8'd5;
    wait_pos(1);
    chk("led_count_5", {24'd0, led_count}, 32'd5);
    repeat (3) @(negedge clock);
    led_count_cfg = 8'd3;
    repeat (5) @(negedge clock);
    chk("led_count_held_5", {24'd0, led_count}, 32'd5);
    wait_pos(1);
    chk("led_count_3", {24'd0, led_count}, 32'd3);

    // Dropping run mid-frame finishes the frame, then idles
    repeat (5) @(negedge clock);
    run = 1'b0;
    fs_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      fs_cnt += int'(frame_start);
      en_cnt += int'(enable);
    end
    chk("stop_frame_start_count", fs_cnt, 32'd0);
    chk("stop_enable_remaining", en_cnt, 32'd14);
    chk("stop_led_count", {24'd0, led_count}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
